// File: rtl/riscv_multicycle_control.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback, with a memory wait timeout and a retire counter.
module riscv_multicycle_control #(
   parameter int MAX_WAIT = 0,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_op,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic             reg_write,
   output logic [1:0]       mem_to_reg,
   output logic             trap,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;

   typedef enum logic [3:0] {
      ST_FETCH     = 4'd0,
      ST_DECODE    = 4'd1,
      ST_MEM_ADDR  = 4'd2,
      ST_MEM_READ  = 4'd3,
      ST_MEM_WB    = 4'd4,
      ST_MEM_WRITE = 4'd5,
      ST_EXEC_R    = 4'd6,
      ST_EXEC_I    = 4'd7,
      ST_ALU_WB    = 4'd8,
      ST_BRANCH    = 4'd9,
      ST_JAL       = 4'd10,
      ST_TRAP      = 4'd11
   } state_t;

   state_t cur_state, nxt_state;
   logic   retire;
   logic   timeout;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cur_state <= ST_FETCH;
      else        cur_state <= nxt_state;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      nxt_state = cur_state;
      retire    = 1'b0;
      case (cur_state)
         ST_FETCH: begin
            if (mem_ready)    nxt_state = ST_DECODE;
            else if (timeout) nxt_state = ST_TRAP;
         end
         ST_DECODE: begin
            case (opcode)
               OP_R:          nxt_state = ST_EXEC_R;
               OP_I:          nxt_state = ST_EXEC_I;
               OP_LW, OP_SW:  nxt_state = ST_MEM_ADDR;
               OP_BEQ:        nxt_state = ST_BRANCH;
               OP_JAL:        nxt_state = ST_JAL;
               default:       nxt_state = ST_TRAP;
            endcase
         end
         ST_MEM_ADDR:  nxt_state = (opcode == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
         ST_MEM_READ: begin
            if (mem_ready)    nxt_state = ST_MEM_WB;
            else if (timeout) nxt_state = ST_TRAP;
         end
         ST_MEM_WRITE: begin
            if (mem_ready) begin
               nxt_state = ST_FETCH;
               retire    = 1'b1;
            end else if (timeout) begin
               nxt_state = ST_TRAP;
            end
         end
         ST_EXEC_R, ST_EXEC_I: nxt_state = ST_ALU_WB;
         ST_MEM_WB, ST_ALU_WB, ST_BRANCH, ST_JAL: begin
            nxt_state = ST_FETCH;
            retire    = 1'b1;
         end
         ST_TRAP:  nxt_state = ST_TRAP;
         default:  nxt_state = ST_TRAP;
      endcase
   end

   // NOTE: outputs are forced to zero while rst_n is low so no enable can pulse during reset.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_op     = 2'b00;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      reg_write  = 1'b0;
      mem_to_reg = 2'b00;
      trap       = 1'b0;
      if (rst_n) begin
         case (cur_state)
            ST_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'b01;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            ST_DECODE: begin
               alu_src_a = 2'b01;
               alu_src_b = 2'b10;
            end
            ST_MEM_ADDR: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b10;
            end
            ST_MEM_READ: begin
               mem_req = 1'b1;
               iord    = 1'b1;
            end
            ST_MEM_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = 2'b01;
            end
            ST_MEM_WRITE: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               mem_we  = 1'b1;
            end
            ST_EXEC_R: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b10;
            end
            ST_EXEC_I: begin
               alu_src_a = 2'b10;
               alu_src_b = 2'b10;
               alu_op    = 2'b10;
            end
            ST_ALU_WB: reg_write = 1'b1;
            ST_BRANCH: begin
               alu_src_a = 2'b10;
               alu_op    = 2'b01;
               pc_src    = 2'b01;
               pc_write  = zero;
            end
            ST_JAL: begin
               pc_write   = 1'b1;
               pc_src     = 2'b01;
               reg_write  = 1'b1;
               mem_to_reg = 2'b10;
            end
            ST_TRAP:  trap = 1'b1;
            default:  trap = 1'b0;
         endcase
      end
   end

   // Counting only while a request is pending and unacknowledged also clears it on entry to any request state.
   if (MAX_WAIT > 0) begin : g_wait
      localparam int WAIT_W = $clog2(MAX_WAIT + 1);
      logic [WAIT_W-1:0] wait_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)                     wait_cnt <= '0;
         else if (mem_req && !mem_ready) wait_cnt <= wait_cnt + WAIT_W'(1);
         else                            wait_cnt <= '0;
      end

      assign timeout = mem_req && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT - 1));
   end else begin : g_no_wait
      assign timeout = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      instret <= '0;
      else if (retire) instret <= instret + CNT_W'(1);
   end

   assign state = cur_state;

endmodule
